// File: rtl/alu_wide_seq.sv
// alu_wide_seq: multi-cycle 16-bit operation sequencer driving an external 8-bit ALU.
// Each accepted request is broken into a low-byte pass, a high-byte pass and, for ADD,
// a carry-propagation pass; the merged 16-bit result and flag are held on a
// valid/ready response channel until consumed.
module alu_wide_seq #(
  parameter int unsigned A = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic [A:0]  alu_cmd,
  output logic [7:0]  alu_inA,
  output logic [7:0]  alu_inB,
  output logic        alu_sc_i,
  input  logic [7:0]  alu_rslt,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic        resp_flag
);

  typedef logic [A:0] cmd_t;

  localparam cmd_t CmdXor  = cmd_t'(4'b0001);
  localparam cmd_t CmdNe   = cmd_t'(4'b0010);
  localparam cmd_t CmdAdd  = cmd_t'(4'b0011);
  localparam cmd_t CmdSelb = cmd_t'(4'b0110);
  localparam cmd_t CmdNop  = cmd_t'(4'b0111);
  localparam cmd_t CmdPar  = cmd_t'(4'b1000);

  localparam logic [2:0] OpXor  = 3'd0;
  localparam logic [2:0] OpAdd  = 3'd1;
  localparam logic [2:0] OpNe   = 3'd2;
  localparam logic [2:0] OpPar  = 3'd3;
  localparam logic [2:0] OpMovb = 3'd4;

  typedef enum logic [2:0] {StIdle, StLo, StHi, StCy, StDone} state_e;

  state_e      r_state;
  logic [2:0]  r_op;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [7:0]  r_lo;
  logic [7:0]  r_hi;
  logic        r_c1;
  logic        r_c2;
  logic [15:0] r_resp_data;
  logic        r_resp_flag;

  cmd_t        w_op_cmd;
  logic [15:0] w_word;
  logic        w_cy_carry;
  logic [15:0] w_fin_data;
  logic        w_fin_flag;

  assign req_ready  = (r_state == StIdle);
  assign resp_valid = (r_state == StDone);
  assign resp_data  = r_resp_data;
  assign resp_flag  = r_resp_flag;
  assign alu_sc_i   = 1'b0;

  // Map the captured request op onto the ALU command used for both byte passes.
  always_comb begin
    w_op_cmd = CmdNop;
    case (r_op)
      OpXor:   w_op_cmd = CmdXor;
      OpAdd:   w_op_cmd = CmdAdd;
      OpNe:    w_op_cmd = CmdNe;
      OpPar:   w_op_cmd = CmdPar;
      OpMovb:  w_op_cmd = CmdSelb;
      default: w_op_cmd = CmdNop;
    endcase
  end

  // Drive the ALU operands and command for the current pass.
  always_comb begin
    alu_cmd = CmdNop;
    alu_inA = 8'h00;
    alu_inB = 8'h00;
    case (r_state)
      StLo: begin
        alu_cmd = w_op_cmd;
        alu_inA = r_a[7:0];
        alu_inB = r_b[7:0];
      end
      StHi: begin
        alu_cmd = w_op_cmd;
        alu_inA = r_a[15:8];
        alu_inB = r_b[15:8];
      end
      StCy: begin
        alu_cmd = CmdAdd;
        alu_inA = r_hi;
        alu_inB = {7'b0, r_c1};
      end
      default: ;
    endcase
  end

  // Final result merge, evaluated in the last pass (HI, or CY for ADD), where the
  // ALU output is the final high byte.
  always_comb begin
    w_word     = {alu_rslt, r_lo};
    w_cy_carry = (alu_rslt < r_hi);
    w_fin_data = w_word;
    w_fin_flag = 1'b0;
    case (r_op)
      OpXor, OpMovb: w_fin_flag = (w_word == 16'h0000);
      // Carry out of bit 15 arises in either the HI pass or the CY pass, never both;
      // the low-byte carry is consumed by the CY pass.
      OpAdd:         w_fin_flag = r_c2 | w_cy_carry;
      OpNe: begin
        w_fin_data = {15'b0, r_lo[0] | alu_rslt[0]};
        w_fin_flag = r_lo[0] | alu_rslt[0];
      end
      OpPar: begin
        w_fin_data = {15'b0, r_lo[0] ^ alu_rslt[0]};
        w_fin_flag = r_lo[0] ^ alu_rslt[0];
      end
      default:       w_fin_flag = 1'b0;
    endcase
  end

  // Sequencer FSM: capture request, run byte passes, hold response until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_op        <= 3'd0;
      r_a         <= 16'h0000;
      r_b         <= 16'h0000;
      r_lo        <= 8'h00;
      r_hi        <= 8'h00;
      r_c1        <= 1'b0;
      r_c2        <= 1'b0;
      r_resp_data <= 16'h0000;
      r_resp_flag <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_op    <= req_op;
            r_a     <= req_a;
            r_b     <= req_b;
            r_state <= StLo;
          end
        end
        StLo: begin
          r_lo <= alu_rslt;
          if (r_op == OpAdd) r_c1 <= (alu_rslt < r_a[7:0]);
          r_state <= StHi;
        end
        StHi: begin
          r_hi <= alu_rslt;
          if (r_op == OpAdd) begin
            r_c2    <= (alu_rslt < r_a[15:8]);
            r_state <= StCy;
          end else begin
            r_resp_data <= w_fin_data;
            r_resp_flag <= w_fin_flag;
            r_state     <= StDone;
          end
        end
        StCy: begin
          r_hi        <= alu_rslt;
          r_c2        <= r_c2 | w_cy_carry;
          r_resp_data <= w_fin_data;
          r_resp_flag <= w_fin_flag;
          r_state     <= StDone;
        end
        StDone: begin
          if (resp_ready) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
